// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode constants, state encodings and control-field encodings for the multi-cycle MIPS control unit
// Contents: opcode localparams, state_t + state constants, datapath mux encodings,
//           ctrl_t control word, op_legal() helper.
package mips_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // Binary-encoded FSM states
    typedef logic [3:0] state_t;
    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXEC     = 4'd6;
    localparam state_t S_ALUWB    = 4'd7;
    localparam state_t S_BRANCH   = 4'd8;
    localparam state_t S_IEXEC    = 4'd9;
    localparam state_t S_IWB      = 4'd10;
    localparam state_t S_JUMP     = 4'd11;
    localparam state_t S_JAL      = 4'd12;
    localparam state_t S_LUI      = 4'd13;

    // Datapath mux / ALU encodings
    localparam logic [1:0] REGDST_RT    = 2'b00;
    localparam logic [1:0] REGDST_RD    = 2'b01;
    localparam logic [1:0] REGDST_RA    = 2'b10;
    localparam logic [1:0] M2R_ALUOUT   = 2'b00;
    localparam logic [1:0] M2R_MDR      = 2'b01;
    localparam logic [1:0] M2R_PC       = 2'b10;
    localparam logic [1:0] M2R_LUI      = 2'b11;
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_4       = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_IMM    = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // jal/lui are only part of the instruction set when the extension is built in.
    function automatic logic op_legal(input logic [5:0] op, input logic ext);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J: op_legal = 1'b1;
            OP_JAL, OP_LUI:                          op_legal = ext;
            default:                                 op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - datapath/memory side bundle of the multi-cycle control unit
// master: the control unit (drives control outputs, retired count; reads op_code, mem_ready)
// slave : the datapath/memory side (drives op_code, mem_ready)
interface multicycle_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op_code;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic [1:0]       RegDst;
    logic [1:0]       MemtoReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op_code, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done, illegal_op, retired
    );

    modport slave (
        output op_code, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done, illegal_op, retired
    );
endinterface

// File: rtl/mc_control_decode.sv
// rtl/mc_control_decode.sv - combinational (state, op_code, mem_ok) to control word
// Ports: state_i current FSM state, op_code_i IR opcode, mem_ok_i memory done
//        (already forced high when the handshake is disabled), ctrl_o control word.
module mc_control_decode
    import mips_pkg::*;
#(
    parameter bit ENABLE_EXT = 1'b1
) (
    input  state_t     state_i,
    input  logic [5:0] op_code_i,
    input  logic       mem_ok_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_4;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC+4 are captured only on the cycle the fetch completes
                ctrl_o.ir_write  = mem_ok_i;
                ctrl_o.pc_write  = mem_ok_i;
            end
            S_DECODE: begin
                // Precompute branch target PC + (imm<<2) into ALUOut
                ctrl_o.alu_src_b  = SRCB_IMM_SH2;
                ctrl_o.illegal_op = ~op_legal(op_code_i, ENABLE_EXT);
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.mem_to_reg = M2R_MDR;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.iord       = 1'b1;
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.instr_done = mem_ok_i;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RD;
                ctrl_o.mem_to_reg = M2R_ALUOUT;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_IEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = (op_code_i == OP_ADDI) ? ALUOP_ADD : ALUOP_IMM;
            end
            S_IWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4, which becomes the $31 return address
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RA;
                ctrl_o.mem_to_reg = M2R_PC;
                ctrl_o.instr_done = 1'b1;
            end
            S_LUI: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = M2R_LUI;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle MIPS control FSM with retired-instruction counter
// Ports: clk rising-edge clock, rst_n async active-low reset,
//        bus (master) op_code/mem_ready in; PC/IR/memory/regfile/ALU/mux controls,
//        instr_done, illegal_op pulses and retired count out.
module multicycle_control_unit
    import mips_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ENABLE_EXT    = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_unit_if.master bus
);

    state_t           state_q, state_d;
    logic             run_q;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_ok;
    ctrl_t            ctrl_raw;
    ctrl_t            ctrl;

    assign mem_ok = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    mc_control_decode #(
        .ENABLE_EXT (ENABLE_EXT)
    ) u_decode (
        .state_i   (state_q),
        .op_code_i (bus.op_code),
        .mem_ok_i  (mem_ok),
        .ctrl_o    (ctrl_raw)
    );

    // run_q is cleared asynchronously with the reset and set on the first edge
    // after release, so every output drops to 0 the moment rst_n falls and the
    // FETCH outputs only appear once the unit has seen a clock out of reset.
    assign ctrl = run_q ? ctrl_raw : '0;

    always_comb begin
        state_d = S_FETCH;
        if (run_q) begin
            case (state_q)
                S_FETCH:    state_d = mem_ok ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    if (!op_legal(bus.op_code, ENABLE_EXT)) begin
                        state_d = S_FETCH;
                    end else begin
                        case (bus.op_code)
                            OP_RTYPE:                         state_d = S_EXEC;
                            OP_LW, OP_SW:                     state_d = S_MEMADR;
                            OP_BEQ:                           state_d = S_BRANCH;
                            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
                            OP_J:                             state_d = S_JUMP;
                            OP_JAL:                           state_d = S_JAL;
                            OP_LUI:                           state_d = S_LUI;
                            default:                          state_d = S_FETCH;
                        endcase
                    end
                end
                S_MEMADR:   state_d = (bus.op_code == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state_d = mem_ok ? S_MEMWB : S_MEMREAD;
                S_MEMWRITE: state_d = mem_ok ? S_FETCH : S_MEMWRITE;
                S_EXEC:     state_d = S_ALUWB;
                S_IEXEC:    state_d = S_IWB;
                default:    state_d = S_FETCH;
            endcase
        end
    end

    // Counter wraps naturally at 2^CNT_W
    always_comb begin
        retired_d = retired_q;
        if (ctrl.instr_done) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            run_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            retired_q <= retired_d;
        end
    end

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.instr_done  = ctrl.instr_done;
    assign bus.illegal_op  = ctrl.illegal_op;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // b0: full feature set; b1: no extension, 4-bit counter; b2: no memory handshake
    multicycle_control_unit_if #(.CNT_W(32)) b0 ();
    multicycle_control_unit_if #(.CNT_W(4))  b1 ();
    multicycle_control_unit_if #(.CNT_W(8))  b2 ();

    multicycle_control_unit #(.CNT_W(32), .MEM_HANDSHAKE(1'b1), .ENABLE_EXT(1'b1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    multicycle_control_unit #(.CNT_W(4), .MEM_HANDSHAKE(1'b1), .ENABLE_EXT(1'b0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    multicycle_control_unit #(.CNT_W(8), .MEM_HANDSHAKE(1'b0), .ENABLE_EXT(1'b1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite RegDst[2]
    //                     MemtoReg[2] RegWrite ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] instr_done illegal_op
    logic [19:0] cw0, cw1, cw2;
    assign cw0 = {b0.PCWrite, b0.PCWriteCond, b0.IorD, b0.MemRead, b0.MemWrite, b0.IRWrite,
                  b0.RegDst, b0.MemtoReg, b0.RegWrite, b0.ALUSrcA, b0.ALUSrcB, b0.ALUOp,
                  b0.PCSource, b0.instr_done, b0.illegal_op};
    assign cw1 = {b1.PCWrite, b1.PCWriteCond, b1.IorD, b1.MemRead, b1.MemWrite, b1.IRWrite,
                  b1.RegDst, b1.MemtoReg, b1.RegWrite, b1.ALUSrcA, b1.ALUSrcB, b1.ALUOp,
                  b1.PCSource, b1.instr_done, b1.illegal_op};
    assign cw2 = {b2.PCWrite, b2.PCWriteCond, b2.IorD, b2.MemRead, b2.MemWrite, b2.IRWrite,
                  b2.RegDst, b2.MemtoReg, b2.RegWrite, b2.ALUSrcA, b2.ALUSrcB, b2.ALUOp,
                  b2.PCSource, b2.instr_done, b2.illegal_op};

    //                             pcw   pcwc  iord  mr    mw    irw   rd     m2r    rw    a     b      aop    pcs    done  ill
    localparam logic [19:0] E_ZERO     = '0;
    localparam logic [19:0] E_FETCH_R  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] E_FETCH_W  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] E_DECODE   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] E_DEC_ILL  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
    localparam logic [19:0] E_EXEC     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] E_ALUWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [19:0] E_MEMADR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] E_MEMREAD  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] E_MEMWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [19:0] E_MEMWR_W  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] E_MEMWR_R  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [19:0] E_BRANCH   = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
    localparam logic [19:0] E_IEXEC_I  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] E_IWB      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [19:0] E_JAL      = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
    localparam logic [19:0] E_JUMP     = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
    localparam logic [19:0] E_LUI      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        b0.op_code = 6'b000000; b0.mem_ready = 1'b1;
        b1.op_code = 6'b111111; b1.mem_ready = 1'b0;
        b2.op_code = 6'b111111; b2.mem_ready = 1'b0;

        // ---- reset ----
        #3;
        chk("reset_cw", {12'b0, cw0}, {12'b0, E_ZERO});
        chk("reset_retired", b0.retired, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("release_before_edge", {12'b0, cw0}, {12'b0, E_ZERO});

        // ---- 1: R-type, 4 cycles ----
        cyc(); chk("r_fetch",  {12'b0, cw0}, {12'b0, E_FETCH_R});
        cyc(); chk("r_decode", {12'b0, cw0}, {12'b0, E_DECODE});
        cyc(); chk("r_exec",   {12'b0, cw0}, {12'b0, E_EXEC});
        cyc(); chk("r_aluwb",  {12'b0, cw0}, {12'b0, E_ALUWB});
        chk("r_retired_pre", b0.retired, 32'd0);
        cyc(); chk("r_retired", b0.retired, 32'd1);

        // ---- 2: lw with 3-cycle memory stall, 8 cycles ----
        b0.op_code = 6'b100011;
        #1 chk("lw_fetch", {12'b0, cw0}, {12'b0, E_FETCH_R});
        cyc(); chk("lw_decode", {12'b0, cw0}, {12'b0, E_DECODE});
        cyc(); chk("lw_memadr", {12'b0, cw0}, {12'b0, E_MEMADR});
        cyc(); b0.mem_ready = 1'b0;
        #1 chk("lw_memread_w1", {12'b0, cw0}, {12'b0, E_MEMREAD});
        cyc(); chk("lw_memread_w2", {12'b0, cw0}, {12'b0, E_MEMREAD});
        cyc(); chk("lw_memread_w3", {12'b0, cw0}, {12'b0, E_MEMREAD});
        cyc(); b0.mem_ready = 1'b1;
        #1 chk("lw_memread_rdy", {12'b0, cw0}, {12'b0, E_MEMREAD});
        cyc(); chk("lw_memwb", {12'b0, cw0}, {12'b0, E_MEMWB});
        cyc(); chk("lw_retired", b0.retired, 32'd2);

        // ---- 3: beq (3 cycles), sw with ready (4 cycles) ----
        b0.op_code = 6'b000100;
        cyc(); chk("beq_decode", {12'b0, cw0}, {12'b0, E_DECODE});
        cyc(); chk("beq_branch", {12'b0, cw0}, {12'b0, E_BRANCH});
        cyc(); chk("beq_retired", b0.retired, 32'd3);
        chk("beq_fetch", {12'b0, cw0}, {12'b0, E_FETCH_R});
        b0.op_code = 6'b101011;
        cyc(); chk("sw_decode", {12'b0, cw0}, {12'b0, E_DECODE});
        cyc(); chk("sw_memadr", {12'b0, cw0}, {12'b0, E_MEMADR});
        cyc(); chk("sw_memwrite", {12'b0, cw0}, {12'b0, E_MEMWR_R});
        cyc(); chk("sw_memwrite_gone", {12'b0, cw0}, {12'b0, E_FETCH_R});
        chk("sw_retired", b0.retired, 32'd4);

        // ---- ori and lui ----
        b0.op_code = 6'b001101;
        cyc(); cyc(); chk("ori_iexec", {12'b0, cw0}, {12'b0, E_IEXEC_I});
        cyc(); chk("ori_iwb", {12'b0, cw0}, {12'b0, E_IWB});
        cyc(); b0.op_code = 6'b001111;
        cyc(); cyc(); chk("lui", {12'b0, cw0}, {12'b0, E_LUI});
        cyc(); chk("lui_retired", b0.retired, 32'd6);

        // ---- 4: jal with extension ----
        b0.op_code = 6'b000011;
        cyc(); cyc(); chk("jal", {12'b0, cw0}, {12'b0, E_JAL});
        cyc(); chk("jal_retired", b0.retired, 32'd7);

        // ---- 5: illegal opcode ----
        b0.op_code = 6'b111111;
        cyc(); chk("ill_decode", {12'b0, cw0}, {12'b0, E_DEC_ILL});
        cyc(); chk("ill_fetch", {12'b0, cw0}, {12'b0, E_FETCH_R});
        chk("ill_retired", b0.retired, 32'd7);
        b0.mem_ready = 1'b0;
        #1 chk("fetch_stall", {12'b0, cw0}, {12'b0, E_FETCH_W});
        cyc(); chk("fetch_stall_hold", {12'b0, cw0}, {12'b0, E_FETCH_W});

        // ---- 6: reset during a stalled sw ----
        b0.mem_ready = 1'b1; b0.op_code = 6'b101011;
        cyc(); cyc(); b0.mem_ready = 1'b0;
        cyc(); chk("sw_stall", {12'b0, cw0}, {12'b0, E_MEMWR_W});
        cyc(); chk("sw_stall_hold", {12'b0, cw0}, {12'b0, E_MEMWR_W});
        b2.op_code = 6'b100011;
        #1 rst_n = 1'b0;
        #1 chk("rst_memwrite", {31'b0, b0.MemWrite}, 32'd0);
        chk("rst_cw", {12'b0, cw0}, {12'b0, E_ZERO});
        chk("rst_retired", b0.retired, 32'd0);
        #2 rst_n = 1'b1;
        #1 chk("rst_release_zero", {12'b0, cw0}, {12'b0, E_ZERO});
        cyc(); chk("rst_fetch", {12'b0, cw0}, {12'b0, E_FETCH_W});

        // ---- handshake disabled: lw in 5 cycles with mem_ready held low ----
        chk("nohs_fetch", {12'b0, cw2}, {12'b0, E_FETCH_R});
        cyc(); chk("nohs_decode", {12'b0, cw2}, {12'b0, E_DECODE});
        cyc(); chk("nohs_memadr", {12'b0, cw2}, {12'b0, E_MEMADR});
        cyc(); chk("nohs_memread", {12'b0, cw2}, {12'b0, E_MEMREAD});
        cyc(); chk("nohs_memwb", {12'b0, cw2}, {12'b0, E_MEMWB});
        cyc(); chk("nohs_retired", {24'b0, b2.retired}, 32'd1);
        b2.op_code = 6'b111111;

        // ---- 4b: jal without extension ----
        b1.op_code = 6'b000011; b1.mem_ready = 1'b1;
        #1 chk("noext_fetch", {12'b0, cw1}, {12'b0, E_FETCH_R});
        cyc(); chk("noext_jal_ill", {12'b0, cw1}, {12'b0, E_DEC_ILL});
        cyc(); chk("noext_back_fetch", {12'b0, cw1}, {12'b0, E_FETCH_R});
        chk("noext_retired", {28'b0, b1.retired}, 32'd0);

        // ---- counter wrap with CNT_W=4: 16 jumps ----
        b1.op_code = 6'b000010;
        cyc(); cyc(); chk("j_noext", {12'b0, cw1}, {12'b0, E_JUMP});
        cyc();
        for (int i = 1; i < 15; i++) begin
            cyc(); cyc(); cyc();
        end
        chk("wrap_15", {28'b0, b1.retired}, 32'd15);
        cyc(); cyc(); cyc();
        chk("wrap_0", {28'b0, b1.retired}, 32'd0);
        chk("nohs_retired_hold", {24'b0, b2.retired}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
